// File: rtl/alu_mdu.sv
// alu_mdu: WIDTH-bit ALU with registered, valid/ready-handshaked result.
// Single-cycle AND/OR/ADD/SUB/SLT/SLTU plus a shift-add unsigned multiply
// (MULTU) that retires one multiplier bit per cycle.
// Optional build macro ALU_MDU_OVF_DETECT_EN enables signed-overflow
// reporting on ovf for ADD/SUB; without it ovf is tied to 0.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; in_ready is high only in IDLE. A result is consumed
// on a rising edge where out_valid && out_ready; out_valid is high only in
// DONE and the result/flags are held stable until consumed. Producers must
// hold in_valid until in_ready; requests made while busy are not queued.
// state_dbg exposes the FSM state (0=IDLE, 1=MUL, 2=DONE) for checkers.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] dataHi,
  output logic             zero,
  output logic             err,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Multiplier working registers
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  // Single-cycle datapath signals
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic             less_s;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             is_mul;
  logic             accept;
  logic             last_iter;

  // Multiply step signals
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;
  assign accept    = in_valid && (state == S_IDLE);
  assign last_iter = (count == CNT_W'(1));

  // SUB as A + ~B + 1; bit WIDTH is the carry out (no borrow when set)
  assign sum_ab  = dataA + dataB;
  assign diff_ab = {1'b0, dataA} + {1'b0, ~dataB} + {{WIDTH{1'b0}}, 1'b1};
  // Signed less-than: differing signs decide directly, else the diff sign
  assign less_s  = (dataA[WIDTH-1] != dataB[WIDTH-1]) ? dataA[WIDTH-1]
                                                      : diff_ab[WIDTH-1];

  // One shift-add step: conditionally add multiplicand, shift {sum,mplier}
  assign mul_sum     = mplier[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
  assign acc_next    = mul_sum[WIDTH:1];
  assign mplier_next = {mul_sum[0], mplier[WIDTH-1:1]};

  // Decode funct and compute single-cycle results
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (Signal)
      F_AND:   alu_res = dataA & dataB;
      F_OR:    alu_res = dataA | dataB;
      F_ADD:   alu_res = sum_ab;
      F_SUB:   alu_res = diff_ab[WIDTH-1:0];
      F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, less_s};
      F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, ~diff_ab[WIDTH]};
      F_MULTU: is_mul  = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (last_iter) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result registers and multiplier datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      dataOut <= '0;
      dataHi  <= '0;
      zero    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= dataA;
              acc    <= '0;
              mplier <= dataB;
              count  <= CNT_W'(WIDTH);
            end else begin
              dataOut <= alu_res;
              dataHi  <= '0;
              zero    <= (alu_res == '0);
              err     <= alu_err;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          count  <= count - CNT_W'(1);
          if (last_iter) begin
            dataOut <= mplier_next;
            dataHi  <= acc_next;
            zero    <= ({acc_next, mplier_next} == '0);
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_MDU_OVF_DETECT_EN
  logic ovf_q;
  logic ovf_next;

  // Signed overflow for ADD/SUB; every other op (incl. MULTU) reports 0
  always_comb begin
    ovf_next = 1'b0;
    case (Signal)
      F_ADD: ovf_next = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                        (sum_ab[WIDTH-1] != dataA[WIDTH-1]);
      F_SUB: ovf_next = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                        (diff_ab[WIDTH-1] != dataA[WIDTH-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  // Overflow flag registered alongside the result at acceptance
  always_ff @(posedge clk) begin
    if (reset)       ovf_q <= 1'b0;
    else if (accept) ovf_q <= ovf_next;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu (WIDTH=32).
// Expected results are pushed to exp_q when an operation is driven and
// popped when the DUT presents out_valid.
module tb_alu_mdu;

  localparam int W  = 32;
  localparam int RW = 2 * W + 3;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULTU = 6'b011001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [5:0]   Signal;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dataOut;
  logic [W-1:0] dataHi;
  logic         zero;
  logic         err;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] exp_q[$];

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataOut(dataOut), .dataHi(dataHi),
    .zero(zero), .err(err), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Packs {dataOut, dataHi, zero, err, ovf}
  function automatic logic [RW-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [5:0] f);
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic [2*W-1:0] p;
    logic           z;
    logic           e;
    logic           o;
    lo = '0; hi = '0; e = 1'b0; o = 1'b0; p = '0;
    case (f)
      F_AND:   lo = a & b;
      F_OR:    lo = a | b;
      F_ADD:   lo = a + b;
      F_SUB:   lo = a - b;
      F_SLT:   lo = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      F_SLTU:  lo = (a < b) ? W'(1) : W'(0);
      F_MULTU: begin
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lo = p[W-1:0];
        hi = p[2*W-1:W];
      end
      default: e = 1'b1;
    endcase
`ifdef ALU_MDU_OVF_DETECT_EN
    if (f == F_ADD) o = (a[W-1] == b[W-1]) && (lo[W-1] != a[W-1]);
    if (f == F_SUB) o = (a[W-1] != b[W-1]) && (lo[W-1] != a[W-1]);
`endif
    z = ({hi, lo} == '0);
    return {lo, hi, z, e, o};
  endfunction

  // ---------------- driver tasks ----------------
  // Present one operation for a single cycle (DUT must be in IDLE) and push
  // its expected result; inputs are scrambled afterwards.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [5:0] f);
    @(negedge clk);
    dataA = a; dataB = b; Signal = f; in_valid = 1'b1;
    exp_q.push_back(model(a, b, f));
    @(negedge clk);
    in_valid = 1'b0;
    dataA = $urandom; dataB = $urandom;
    Signal = 6'($urandom_range(0, 63));
  endtask

  // Wait (bounded) for out_valid; lat counts cycles since acceptance.
  task automatic wait_out(input int budget, output int lat,
                          output logic [RW-1:0] obs, output logic ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < budget) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) ready_seen = 1'b1;
    obs = {dataOut, dataHi, zero, err, ovf};
  endtask

  // Accept the result for one cycle
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dataA = '0; dataB = '0; Signal = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    n_cmp++;
    if ({dataOut, dataHi, zero, err, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%h z%b e%b o%b expected all 0",
               dataOut, dataHi, zero, err, ovf);
    end
  endtask

  task automatic test_single_ops();
    logic [W-1:0]  ta[4] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0]  tb[4] = '{32'd1, 32'd5, 32'd1, 32'd1};
    logic [5:0]    tf[4] = '{F_ADD, F_SUB, F_SLT, F_SLTU};
    logic [W-1:0]  tk[4] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0};
    logic [5:0]    fset[6] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLTU};
    logic [RW-1:0] obs;
    logic [RW-1:0] exp;
    logic [W-1:0]  a, b;
    logic [5:0]    f;
    logic          rs;
    int            lat;
    for (int i = 0; i < 28; i++) begin
      if (i < 4) begin
        a = ta[i]; b = tb[i]; f = tf[i];
      end else begin
        a = pick_operand(); b = pick_operand();
        if ($urandom_range(0, 7) == 0) f = 6'($urandom_range(0, 63));
        else f = fset[$urandom_range(0, 5)];
        if (f == F_MULTU) f = 6'b000000;
      end
      send(a, b, f);
      wait_out(5, lat, obs, rs);
      exp = exp_q.pop_front();
      n_cmp++;
      if (lat != 1) begin
        n_bad++; $display("FAIL single_latency[%0d]: got %0d expected 1", i, lat);
      end
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL single_result[%0d] f=%b a=%h b=%h: got %h expected %h",
                 i, f, a, b, obs, exp);
      end
      if (i < 4) begin
        n_cmp++;
        if (dataOut !== tk[i]) begin
          n_bad++;
          $display("FAIL directed_dataOut[%0d]: got %h expected %h", i, dataOut, tk[i]);
        end
      end
      release_out();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL single_release[%0d]: got valid=%b ready=%b expected 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_multu();
    logic [RW-1:0] obs;
    logic [RW-1:0] exp;
    logic [W-1:0]  a, b;
    logic          rs;
    int            lat;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        1: begin a = 32'h0;         b = W'($urandom);  end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      send(a, b, F_MULTU);
      wait_out(60, lat, obs, rs);
      exp = exp_q.pop_front();
      n_cmp++;
      if (lat != W + 1) begin
        n_bad++; $display("FAIL multu_latency[%0d]: got %0d expected %0d", i, lat, W + 1);
      end
      n_cmp++;
      if (rs !== 1'b0) begin
        n_bad++; $display("FAIL multu_in_ready[%0d]: got high during op expected 0", i);
      end
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL multu_result[%0d] a=%h b=%h: got %h expected %h", i, a, b, obs, exp);
      end
      if (i == 0) begin
        n_cmp++;
        if (dataHi !== 32'hFFFF_FFFE || dataOut !== 32'h0000_0001) begin
          n_bad++;
          $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", dataHi, dataOut);
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] obs;
    logic [RW-1:0] exp;
    logic          rs;
    int            lat;
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, F_ADD);
    wait_out(5, lat, obs, rs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL bp_result: got %h expected %h", obs, exp);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; dataA = W'($urandom); dataB = W'($urandom); Signal = F_OR;
      @(negedge clk);
      n_cmp++;
      if ({dataOut, dataHi, zero, err, ovf} !== exp || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got %h v%b r%b expected %h v1 r0",
                 c, {dataOut, dataHi, zero, err, ovf}, out_valid, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL bp_no_second_accept: got out_valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [RW-1:0] obs;
    logic [RW-1:0] exp;
    logic [RW-1:0] dropped;
    logic          rs;
    logic          seen;
    int            lat;
    send(W'($urandom), W'($urandom), F_MULTU);
    dropped = exp_q.pop_back();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_bad++; $display("FAIL midmul_state: got %0d expected 1", state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || state_dbg !== 2'd0 ||
        {dataOut, dataHi, zero, err, ovf} !== '0) begin
      n_bad++;
      $display("FAIL midmul_reset: got v%b s%0d out %h/%h z%b e%b o%b expected all 0",
               out_valid, state_dbg, dataOut, dataHi, zero, err, ovf);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midmul_discard: got out_valid after reset expected none");
    end
    send(32'hF0F0_F0F0, 32'hFF00_FF00, F_AND);
    wait_out(5, lat, obs, rs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp || dataOut !== 32'hF000_F000) begin
      n_bad++;
      $display("FAIL midmul_and: got %h expected %h (dataOut f000f000)", obs, exp);
    end
    release_out();
  endtask

  task automatic test_illegal();
    logic [RW-1:0] obs;
    logic [RW-1:0] exp;
    logic          rs;
    int            lat;
    send(W'($urandom), W'($urandom), 6'b111111);
    wait_out(5, lat, obs, rs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp || err !== 1'b1 || dataOut !== '0 || dataHi !== '0) begin
      n_bad++;
      $display("FAIL illegal: got %h err=%b expected %h err=1", obs, err, exp);
    end
    release_out();
    send(32'h0000_00F0, 32'h0000_000F, F_OR);
    wait_out(5, lat, obs, rs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp || err !== 1'b0 || dataOut !== 32'h0000_00FF) begin
      n_bad++;
      $display("FAIL illegal_then_or: got %h err=%b expected %h err=0", obs, err, exp);
    end
    release_out();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_ops();
    test_multu();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
